// File: rtl/s2p_deser.sv
// rtl/s2p_deser.sv - serial-to-parallel deserializer with registered valid/ready output
//
// Purpose: collects an LSB-first serial stream (one bit per clk while vld=1) into
//          WIDTH-bit words, presents them on a registered valid/ready port, flags
//          broken frames (frag) and words dropped while the output was full (ovf).
// Build option: PARITY_CHK_EN appends one even-parity bit per frame and drives perr.
// Ports:
//   clk, n_rst        clock (rising edge), asynchronous active-low reset
//   data, vld         serial bit and its valid
//   dout, dout_vld    assembled word (first bit in dout[0]) and its valid
//   dout_rdy          consumer accept
//   frag              1-cycle pulse: partial frame discarded
//   ovf, ovf_clr      sticky overflow flag and its synchronous clear
//   perr              parity error for the word on dout (0 without PARITY_CHK_EN)
module s2p_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             data,
    input  logic             vld,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             frag,
    output logic             ovf,
    input  logic             ovf_clr,
    output logic             perr
);

`ifdef PARITY_CHK_EN
    localparam int FRAME = WIDTH + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, PAR = 2'd2} state_t;
`else
    localparam int FRAME = WIDTH;
    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1} state_t;
`endif
    localparam int CW = $clog2(FRAME + 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] sh;
    logic             shift_en;
    logic             done;
    logic             frag_set;
    logic [WIDTH-1:0] word;
    logic             word_perr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shift_en  = 1'b0;
        done      = 1'b0;
        frag_set  = 1'b0;
        case (state)
            IDLE: begin
                if (vld) begin
                    shift_en  = 1'b1;
                    cnt_nxt   = CW'(1);
                    state_nxt = RECV;
                end
            end
            RECV: begin
                if (vld) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
`ifdef PARITY_CHK_EN
                        cnt_nxt   = CW'(WIDTH);
                        state_nxt = PAR;
`else
                        done      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
`endif
                    end else begin
                        cnt_nxt = cnt + CW'(1);
                    end
                end else begin
                    frag_set  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
`ifdef PARITY_CHK_EN
            PAR: begin
                // Parity bit is checked, never shifted into the data word.
                cnt_nxt   = '0;
                state_nxt = IDLE;
                if (vld) begin
                    done = 1'b1;
                end else begin
                    frag_set = 1'b1;
                end
            end
`endif
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef PARITY_CHK_EN
    assign word      = sh;
    assign word_perr = ^{data, sh};
`else
    assign word      = {data, sh[WIDTH-1:1]};
    assign word_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sh <= '0;
        end else if (shift_en) begin
            sh <= {data, sh[WIDTH-1:1]};
        end
    end

    // A completing word may replace the current one on the same edge it is accepted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            frag     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            frag <= frag_set;
            if (done && (!dout_vld || dout_rdy)) begin
                dout     <= word;
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
            if (done && dout_vld && !dout_rdy) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perr <= 1'b0;
        end else if (done && (!dout_vld || dout_rdy)) begin
            perr <= word_perr;
        end
    end
`else
    assign perr = word_perr;
`endif

endmodule

// File: tb/tb_s2p_deser.sv
// tb/tb_s2p_deser.sv - table-driven self-checking bench for s2p_deser (WIDTH=4)
module tb_s2p_deser;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       data = 1'b0;
    logic       vld = 1'b0;
    logic [3:0] dout;
    logic       dout_vld;
    logic       dout_rdy = 1'b0;
    logic       frag;
    logic       ovf;
    logic       ovf_clr = 1'b0;
    logic       perr;

    int n_cmp = 0;
    int n_bad = 0;

    s2p_deser #(.WIDTH(4)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .data     (data),
        .vld      (vld),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_rdy (dout_rdy),
        .frag     (frag),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .perr     (perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic       d;
        logic       r;
        logic       c;
        logic [3:0] e_dout;
        logic       e_vld;
        logic       e_frag;
        logic       e_ovf;
        logic       e_perr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic v, d, r, c, input logic [3:0] ed,
                       input logic ev, ef, eo, ep);
        vec_t x;
        x.v = v; x.d = d; x.r = r; x.c = c;
        x.e_dout = ed; x.e_vld = ev; x.e_frag = ef; x.e_ovf = eo; x.e_perr = ep;
        vq.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input vec_t x);
        chk("dout", idx, dout, x.e_dout);
        chk("dout_vld", idx, {3'b0, dout_vld}, {3'b0, x.e_vld});
        chk("frag", idx, {3'b0, frag}, {3'b0, x.e_frag});
        chk("ovf", idx, {3'b0, ovf}, {3'b0, x.e_ovf});
        chk("perr", idx, {3'b0, perr}, {3'b0, x.e_perr});
    endtask

    task automatic run_rows(input int base);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            vld = vq[i].v; data = vq[i].d; dout_rdy = vq[i].r; ovf_clr = vq[i].c;
            @(posedge clk);
            #1;
            chk_all(base + i, vq[i]);
        end
        vq.delete();
    endtask

    initial begin
        vec_t z;
        z.v = 0; z.d = 0; z.r = 0; z.c = 0;
        z.e_dout = 4'h0; z.e_vld = 0; z.e_frag = 0; z.e_ovf = 0; z.e_perr = 0;

        #1;
        chk_all(-1, z);
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

`ifdef PARITY_CHK_EN
        // 1,1,0,1 + parity 1: good word
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,0,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'hB,1,0,0,0);
        // same data + parity 0: bad parity, word still delivered
        add(1,1,1,0, 4'hB,0,0,0,0);
        add(1,1,1,0, 4'hB,0,0,0,0);
        add(1,0,1,0, 4'hB,0,0,0,0);
        add(1,1,1,0, 4'hB,0,0,0,0);
        add(1,0,1,0, 4'hB,1,0,0,1);
        add(0,0,1,0, 4'hB,0,0,0,1);
        // vld drops where the parity bit is due
        add(1,0,1,0, 4'hB,0,0,0,1);
        add(1,0,1,0, 4'hB,0,0,0,1);
        add(1,0,1,0, 4'hB,0,0,0,1);
        add(1,0,1,0, 4'hB,0,0,0,1);
        add(0,0,1,0, 4'hB,0,1,0,1);
        add(0,0,1,0, 4'hB,0,0,0,1);
        run_rows(0);
`else
        // single word 1,1,0,1 -> B
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,0,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'hB,1,0,0,0);
        add(0,0,1,0, 4'hB,0,0,0,0);
        // two words with consumer stalled: second dropped, ovf sticky then cleared
        add(1,1,0,0, 4'hB,0,0,0,0);
        add(1,0,0,0, 4'hB,0,0,0,0);
        add(1,0,0,0, 4'hB,0,0,0,0);
        add(1,0,0,0, 4'h1,1,0,0,0);
        add(1,0,0,0, 4'h1,1,0,0,0);
        add(1,1,0,0, 4'h1,1,0,0,0);
        add(1,1,0,0, 4'h1,1,0,0,0);
        add(1,1,0,0, 4'h1,1,0,1,0);
        add(0,0,0,0, 4'h1,1,0,1,0);
        add(0,0,0,1, 4'h1,1,0,0,0);
        add(0,0,1,0, 4'h1,0,0,0,0);
        // broken frame then a clean 0,1,0,1 -> A
        add(1,0,1,0, 4'h1,0,0,0,0);
        add(1,1,1,0, 4'h1,0,0,0,0);
        add(0,0,1,0, 4'h1,0,1,0,0);
        add(0,0,1,0, 4'h1,0,0,0,0);
        add(1,0,1,0, 4'h1,0,0,0,0);
        add(1,1,1,0, 4'h1,0,0,0,0);
        add(1,0,1,0, 4'h1,0,0,0,0);
        add(1,1,1,0, 4'hA,1,0,0,0);
        add(0,0,1,0, 4'hA,0,0,0,0);
        // back-to-back F then 4; accept and reload on the same edge
        add(1,1,1,0, 4'hA,0,0,0,0);
        add(1,1,1,0, 4'hA,0,0,0,0);
        add(1,1,1,0, 4'hA,0,0,0,0);
        add(1,1,0,0, 4'hF,1,0,0,0);
        add(1,0,0,0, 4'hF,1,0,0,0);
        add(1,0,0,0, 4'hF,1,0,0,0);
        add(1,1,0,0, 4'hF,1,0,0,0);
        add(1,0,1,0, 4'h4,1,0,0,0);
        add(0,0,1,0, 4'h4,0,0,0,0);
        // overflow set and clear on the same edge: set wins
        add(1,1,0,0, 4'h4,0,0,0,0);
        add(1,0,0,0, 4'h4,0,0,0,0);
        add(1,1,0,0, 4'h4,0,0,0,0);
        add(1,0,0,0, 4'h5,1,0,0,0);
        add(1,1,0,0, 4'h5,1,0,0,0);
        add(1,1,0,0, 4'h5,1,0,0,0);
        add(1,1,0,0, 4'h5,1,0,0,0);
        add(1,1,0,1, 4'h5,1,0,1,0);
        add(0,0,0,1, 4'h5,1,0,0,0);
        add(0,0,1,0, 4'h5,0,0,0,0);
        // three bits of a frame, then reset mid-frame
        add(1,1,1,0, 4'h5,0,0,0,0);
        add(1,1,1,0, 4'h5,0,0,0,0);
        add(1,0,1,0, 4'h5,0,0,0,0);
        run_rows(0);

        @(negedge clk);
        n_rst = 1'b0; vld = 1'b0; data = 1'b0;
        #1;
        chk_all(1000, z);
        @(posedge clk);
        #1;
        chk_all(1001, z);
        @(negedge clk);
        n_rst = 1'b1;

        // fresh frame 0,1,1,0 -> 6
        add(1,0,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,1,1,0, 4'h0,0,0,0,0);
        add(1,0,1,0, 4'h6,1,0,0,0);
        add(0,0,1,0, 4'h6,0,0,0,0);
        run_rows(2000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
